// File: rtl/module_encoder_if.sv
// Upstream hit/token stream feeding the module encoder.
// The source owns valid/eor/data; the encoder owns ready.
interface module_encoder_if;
    logic        in_valid;
    logic        in_ready;
    logic        in_eor;
    logic [23:0] in_data;

    modport master (output in_valid, output in_eor, output in_data, input in_ready);
    modport slave  (input in_valid, input in_eor, input in_data, output in_ready);
endinterface

// File: rtl/module_encoder.sv
// Module readout emulator: serialises TBM header, ROC headers with pixel hits,
// TBM trailer and idle fill onto a 4-bit nibble stream advanced by ena.
module module_encoder #(
    parameter int unsigned GAP = 4
) (
    input  logic              clk80,
    input  logic              reset_n,
    input  logic              ena,
    input  logic              start,
    input  logic [15:0]       tbm_hdr_data,
    input  logic [15:0]       tbm_trl_data,
    input  logic [3:0]        nroc,
    input  logic [1:0]        roc_stat,
    module_encoder_if.slave   up,
    output logic [3:0]        dout,
    output logic              busy,
    output logic              frame_start,
    output logic              underrun
);

    typedef enum logic [2:0] {StIdle, StArm, StTh, StRh, StPx, StWait, StTt, StGap} state_e;

    state_e      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [3:0]  gap_q, gap_d;
    logic [3:0]  roc_q, roc_d;
    logic [15:0] hdr_q, hdr_d, trl_q, trl_d;
    logic [1:0]  stat_q, stat_d;
    logic [23:0] data_q, data_d;
    logic        eor_q, eor_d, have_q, have_d;
    logic [3:0]  dout_q, dout_d, nib_next;
    logic        busy_q, busy_d, ready_q, ready_d, fs_q, fs_d, underrun_q, underrun_d;
    logic        xfer, have, w_eor, take;
    logic [23:0] w_data;

    // A word may arrive on any clk80 edge but is only consumed at the next ena decision point.
    assign xfer   = ready_q & up.in_valid;
    assign have   = have_q | xfer;
    assign w_eor  = have_q ? eor_q : up.in_eor;
    assign w_data = have_q ? data_q : up.in_data;
    assign take   = ena & (((state_q == StRh) & (cnt_q == 3'd2)) |
                           ((state_q == StPx) & (cnt_q == 3'd5)) | (state_q == StWait));

    function automatic logic [3:0] nib_at(logic [27:0] v, logic [2:0] i);
        return v[5'd27 - {i, 2'b00} -: 4];
    endfunction

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        gap_d      = gap_q;
        roc_d      = roc_q;
        hdr_d      = hdr_q;
        trl_d      = trl_q;
        stat_d     = stat_q;
        data_d     = data_q;
        eor_d      = eor_q;
        have_d     = have_q;
        busy_d     = busy_q;
        ready_d    = 1'b0;
        fs_d       = 1'b0;
        underrun_d = underrun_q;
        if (xfer) begin
            have_d = 1'b1;
            eor_d  = up.in_eor;
            data_d = up.in_data;
        end
        unique case (state_q)
            StIdle: if (start) begin
                hdr_d      = tbm_hdr_data;
                trl_d      = tbm_trl_data;
                roc_d      = nroc;
                stat_d     = roc_stat;
                underrun_d = 1'b0;
                busy_d     = 1'b1;
                state_d    = StArm;
            end
            StArm: if (ena) begin
                state_d = StTh;
                cnt_d   = 3'd0;
                fs_d    = 1'b1;
            end
            StTh: if (ena) begin
                if (cnt_q == 3'd6) begin
                    state_d = (roc_q != 4'd0) ? StRh : StTt;
                    cnt_d   = 3'd0;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            StRh: if (ena && cnt_q != 3'd2) begin
                cnt_d   = cnt_q + 3'd1;
                ready_d = (cnt_q == 3'd1);
            end
            StPx: if (ena && cnt_q != 3'd5) begin
                cnt_d   = cnt_q + 3'd1;
                ready_d = (cnt_q == 3'd4);
            end
            StWait: ;
            StTt: if (ena) begin
                if (cnt_q == 3'd6) begin
                    cnt_d = 3'd0;
                    if (GAP == 0) begin
                        state_d = StIdle;
                        busy_d  = 1'b0;
                    end else begin
                        state_d = StGap;
                        gap_d   = 4'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            StGap: if (ena) begin
                if (gap_q == 4'(GAP)) begin
                    state_d = StIdle;
                    busy_d  = 1'b0;
                end else begin
                    gap_d = gap_q + 4'd1;
                end
            end
            default: state_d = StIdle;
        endcase
        if (take) begin
            cnt_d = 3'd0;
            if (have) begin
                have_d = 1'b0;
                if (!w_eor) begin
                    state_d = StPx;
                    data_d  = w_data;
                end else begin
                    roc_d   = roc_q - 4'd1;
                    state_d = (roc_q != 4'd1) ? StRh : StTt;
                end
            end else begin
                state_d    = StWait;
                underrun_d = 1'b1;
                ready_d    = 1'b1;
            end
        end
    end

    // The nibble driven on an ena edge is the one selected by the next state/counter.
    always_comb begin
        nib_next = 4'hF;
        unique case (state_d)
            StTh:    nib_next = nib_at({12'h7FC, hdr_q}, cnt_d);
            StRh:    nib_next = nib_at({8'h7F, 2'b10, stat_q, 16'h0000}, cnt_d);
            StPx:    nib_next = nib_at({data_d, 4'h0}, cnt_d);
            StTt:    nib_next = nib_at({12'h7FE, trl_q}, cnt_d);
            default: nib_next = 4'hF;
        endcase
        dout_d = ena ? nib_next : dout_q;
    end

    always_ff @(posedge clk80 or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            cnt_q      <= 3'd0;
            gap_q      <= 4'd0;
            roc_q      <= 4'd0;
            hdr_q      <= 16'h0000;
            trl_q      <= 16'h0000;
            stat_q     <= 2'b00;
            data_q     <= 24'h000000;
            eor_q      <= 1'b0;
            have_q     <= 1'b0;
            dout_q     <= 4'hF;
            busy_q     <= 1'b0;
            ready_q    <= 1'b0;
            fs_q       <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            gap_q      <= gap_d;
            roc_q      <= roc_d;
            hdr_q      <= hdr_d;
            trl_q      <= trl_d;
            stat_q     <= stat_d;
            data_q     <= data_d;
            eor_q      <= eor_d;
            have_q     <= have_d;
            dout_q     <= dout_d;
            busy_q     <= busy_d;
            ready_q    <= ready_d;
            fs_q       <= fs_d;
            underrun_q <= underrun_d;
        end
    end

    assign dout        = dout_q;
    assign busy        = busy_q;
    assign up.in_ready = ready_q;
    assign frame_start = fs_q;
    assign underrun    = underrun_q;

endmodule

// File: tb/tb_module_encoder.sv
// Directed bench for module_encoder: table of frames with hand-computed nibble
// streams, plus sequences for spurious starts and asynchronous reset.
module tb_module_encoder;

    logic        clk80 = 1'b0;
    logic        reset_n = 1'b0;
    logic        ena = 1'b1;
    logic        start = 1'b0;
    logic [15:0] tbm_hdr_data = '0, tbm_trl_data = '0;
    logic [3:0]  nroc = '0;
    logic [1:0]  roc_stat = '0;
    logic [3:0]  dout;
    logic        busy, frame_start, underrun;

    module_encoder_if up();

    module_encoder #(.GAP(4)) dut (
        .clk80        (clk80),
        .reset_n      (reset_n),
        .ena          (ena),
        .start        (start),
        .tbm_hdr_data (tbm_hdr_data),
        .tbm_trl_data (tbm_trl_data),
        .nroc         (nroc),
        .roc_stat     (roc_stat),
        .up           (up),
        .dout         (dout),
        .busy         (busy),
        .frame_start  (frame_start),
        .underrun     (underrun)
    );

    always #5 clk80 = ~clk80;

    typedef struct {
        logic [15:0]      hdr;
        logic [15:0]      trl;
        logic [3:0]       nroc;
        logic [1:0]       stat;
        int               per;
        int               gate;
        int               nw;
        logic [3:0][24:0] w;
        int               len;
        logic [159:0]     exp;
        int               rdy;
    } vec_t;

    vec_t        vecs [6];
    logic [24:0] src_q [$];
    logic [3:0]  got [$];
    int checks = 0, errors = 0;
    int per = 1, phase = 0, gate_cnt = 0;
    int ready_cnt, fs_cnt, fs_bad, stable_err;
    bit rec = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic drive_src();
        up.in_valid = (src_q.size() > 0) && (gate_cnt == 0);
        if (src_q.size() > 0) {up.in_eor, up.in_data} = src_q[0];
        else {up.in_eor, up.in_data} = '0;
    endtask

    task automatic tick();
        logic       fire, was_ena;
        logic [3:0] prev;
        fire    = up.in_valid && up.in_ready;
        if (up.in_ready) ready_cnt++;
        if (up.in_ready && !up.in_valid && gate_cnt > 0) gate_cnt--;
        was_ena = ena;
        prev    = dout;
        @(posedge clk80);
        #1;
        if (fire) void'(src_q.pop_front());
        if (!was_ena && dout !== prev) stable_err++;
        if (rec && was_ena && busy) got.push_back(dout);
        if (frame_start) begin
            fs_cnt++;
            if (!(rec && was_ena && got.size() == 1)) fs_bad++;
        end
        drive_src();
        phase++;
        ena = (phase % per) == 0;
    endtask

    task automatic start_frame(input int k);
        tbm_hdr_data = vecs[k].hdr;
        tbm_trl_data = vecs[k].trl;
        nroc         = vecs[k].nroc;
        roc_stat     = vecs[k].stat;
        per          = vecs[k].per;
        gate_cnt     = vecs[k].gate;
        src_q.delete();
        for (int i = 0; i < vecs[k].nw; i++) src_q.push_back(vecs[k].w[i]);
        ready_cnt = 0; fs_cnt = 0; fs_bad = 0; stable_err = 0;
        got.delete();
        drive_src();
        start = 1'b1;
        tick();
        start = 1'b0;
        rec   = 1'b1;
    endtask

    task automatic run_frame(input int k, input int sp1, input int sp2, input int sp3);
        int            n, mism;
        logic [159:0]  t;
        start_frame(k);
        n = 0;
        while (busy && n < 2000) begin
            start = (n == sp1) || (n == sp2) || (n == sp3);
            tick();
            n++;
        end
        start = 1'b0;
        rec   = 1'b0;
        check($sformatf("v%0d busy timeout", k), 32'(busy), 32'd0);
        check($sformatf("v%0d stream length", k), got.size(), vecs[k].len);
        mism = 0;
        for (int i = 0; i < got.size() && i < vecs[k].len; i++) begin
            t = vecs[k].exp >> (4 * (vecs[k].len - 1 - i));
            if (got[i] !== t[3:0]) begin
                if (mism == 0)
                    $display("FAIL v%0d nibble %0d: got %h expected %h", k, i, got[i], t[3:0]);
                mism++;
            end
        end
        check($sformatf("v%0d nibble mismatches", k), mism, 0);
        check($sformatf("v%0d in_ready cycles", k), ready_cnt, vecs[k].rdy);
        check($sformatf("v%0d frame_start pulses", k), fs_cnt, 1);
        check($sformatf("v%0d frame_start placement", k), fs_bad, 0);
        check($sformatf("v%0d dout moved off ena", k), stable_err, 0);
        check($sformatf("v%0d underrun", k), 32'(underrun), 32'(vecs[k].gate > 0));
        check($sformatf("v%0d words left", k), src_q.size(), 0);
    endtask

    initial begin
        vecs[0] = '{hdr: 16'hA53C, trl: 16'h0081, nroc: 4'd0, stat: 2'b00, per: 1, gate: 0,
                    nw: 0, w: '0, len: 18, exp: 160'h7FCA53C7FE0081FFFF, rdy: 0};
        vecs[1] = '{hdr: 16'hA53C, trl: 16'h0081, nroc: 4'd2, stat: 2'b10, per: 1, gate: 0,
                    nw: 3, w: '0, len: 30, exp: 160'h7FCA53C7FA1234567FA7FE0081FFFF, rdy: 3};
        vecs[1].w[0] = {1'b0, 24'h123456};
        vecs[1].w[1] = {1'b1, 24'h0};
        vecs[1].w[2] = {1'b1, 24'h0};
        vecs[2] = vecs[1];
        vecs[2].per = 5;
        vecs[3] = '{hdr: 16'h0F0F, trl: 16'hBEEF, nroc: 4'd1, stat: 2'b01, per: 3, gate: 0,
                    nw: 3, w: '0, len: 33, exp: 160'h7FC0F0F7F9ABCDEF0001117FEBEEFFFFF, rdy: 3};
        vecs[3].w[0] = {1'b0, 24'hABCDEF};
        vecs[3].w[1] = {1'b0, 24'h000111};
        vecs[3].w[2] = {1'b1, 24'h0};
        // Source withholds data for three ena edges at the first ROC handshake.
        vecs[4] = vecs[1];
        vecs[4].gate = 3;
        vecs[4].len  = 33;
        vecs[4].exp  = 160'h7FCA53C7FAFFF1234567FA7FE0081FFFF;
        vecs[4].rdy  = 6;
        vecs[5] = '{hdr: 16'h8001, trl: 16'h4002, nroc: 4'd3, stat: 2'b11, per: 2, gate: 0,
                    nw: 3, w: '0, len: 27, exp: 160'h7FC80017FB7FB7FB7FE4002FFFF, rdy: 3};
        vecs[5].w[0] = {1'b1, 24'h0};
        vecs[5].w[1] = {1'b1, 24'h0};
        vecs[5].w[2] = {1'b1, 24'h0};

        ready_cnt = 0; fs_cnt = 0; fs_bad = 0; stable_err = 0;
        drive_src();
        #12;
        check("reset dout", 32'(dout), 32'hF);
        check("reset busy", 32'(busy), 32'd0);
        check("reset in_ready", 32'(up.in_ready), 32'd0);
        check("reset frame_start", 32'(frame_start), 32'd0);
        check("reset underrun", 32'(underrun), 32'd0);
        @(negedge clk80);
        reset_n = 1'b1;
        repeat (2) tick();

        // Vector 5 follows the underrun frame, so its underrun=0 shows start clears it.
        for (int k = 0; k < 6; k++) begin
            run_frame(k, -1, -1, -1);
            repeat (3) tick();
        end

        // Starts mid-PX, mid-GAP and on the edge busy drops must all be ignored.
        run_frame(1, 12, 27, 30);
        repeat (2) tick();
        check("spurious start busy", 32'(busy), 32'd0);
        check("spurious start frame_start", 32'(fs_cnt), 32'd1);

        start_frame(1);
        repeat (12) tick();
        #2 reset_n = 1'b0;
        #1;
        check("async reset dout", 32'(dout), 32'hF);
        check("async reset busy", 32'(busy), 32'd0);
        check("async reset in_ready", 32'(up.in_ready), 32'd0);
        rec = 1'b0;
        src_q.delete();
        drive_src();
        @(negedge clk80);
        reset_n = 1'b1;
        repeat (2) tick();
        run_frame(0, -1, -1, -1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/module_encoder.md
Name: module_encoder

Overview:
- Transmit-side counterpart of the deser400 module readout decoder.
- Serialises one module readout frame onto a 4-bit nibble stream:
  - TBM header
  - per-ROC headers, each followed by its pixel hits
  - TBM trailer
  - idle fill (1111) between frames
- Used as a module emulator for loopback tests of the deser400 receive path. Hits arrive from an upstream valid/ready source.

Parameters:
GAP, 4, minimum number of idle nibbles (1111) emitted after a trailer before the next TBM header may start (0..15)

Ports:
clk80  in  1  system clock
reset_n  in  1  asynchronous, active-low reset
ena  in  1  nibble strobe; dout advances only on clk80 edges with ena=1
start  in  1  frame request; sampled only while busy=0
tbm_hdr_data  in  16  TBM header payload; latched on accepted start
tbm_trl_data  in  16  TBM trailer payload; latched on accepted start
nroc  in  4  number of ROCs in the frame (0..15); latched on accepted start
roc_stat  in  2  ROC header status bits for every ROC in the frame; latched on accepted start
in_valid  in  1  upstream word valid
in_ready  out  1  upstream word accepted when in_valid & in_ready
in_eor  in  1  1 = end-of-ROC token (in_data ignored); 0 = pixel hit
in_data  in  24  pixel hit, 6 nibbles, MSB nibble first
dout  out  4  serial nibble stream
busy  out  1  frame in progress, including the GAP phase
frame_start  out  1  one-cycle pulse on the edge that drives the first header nibble
underrun  out  1  sticky; set on a data underrun, cleared on accepted start

Behaviour:
- Reset values: dout=4'b1111, busy=0, in_ready=0, frame_start=0, underrun=0, state=IDLE. A reset mid-frame aborts immediately to these values.
- All outputs are registered. dout changes only on ena edges. Between ena edges dout holds its value. Nibbles are MSB-first.
- Start handling:
  - start is accepted on any clk80 edge with busy=0. On that edge: latch the frame inputs, clear underrun, set busy=1.
  - The first header nibble is driven at the first ena edge strictly after the accepted start edge; frame_start pulses on that edge.
  - start while busy=1 is ignored.
- Frame segments:
  - TBM header (7 nibbles): 0111 1111 1100, then tbm_hdr_data[15:12], [11:8], [7:4], [3:0].
  - ROC header (3 nibbles): 0111 1111 10 followed by roc_stat.
  - Pixel (6 nibbles): in_data[23:20] … in_data[3:0].
  - TBM trailer (7 nibbles): 0111 1111 1110, then tbm_trl_data nibbles MSB first.
- State machine: IDLE → TH → (RH → {PX}* )×nroc → TT → GAP → IDLE.
  - A 3-bit nibble counter runs within each state and resets on every state change.
  - Remaining ROC count is loaded with nroc.
- Decision points: the last nibble of TH, RH and PX. The next segment starts on the next ena edge.
  - TH last nibble: go to RH if nroc≠0, else TT.
  - RH last nibble and PX last nibble are handshake points:
    - in_ready=1 for exactly the clk80 cycle that carries that ena edge.
    - Hit (in_eor=0) → PX with in_data captured.
    - Token (in_eor=1) → decrement the ROC count; go to RH if the count is still ≠0, else TT.
  - in_ready is 0 at all other times.
- Underrun: in_valid=0 at a handshake point →
  - enter WAIT, drive 1111 on each ena edge, set underrun;
  - in_ready is asserted on every ena edge in WAIT until a transfer occurs, then proceed as at a normal handshake point.
- TT last nibble → GAP. GAP emits GAP idle nibbles (1111), then goes to IDLE with busy=0 (GAP=0: straight to IDLE).
  - A start arriving in GAP is ignored.
  - A start on the same edge busy drops is not accepted.
- No escaping of pixel payloads that mimic the 0111 1111 1 marker; the upstream source guarantees valid hit data.

Test Plan:
- ena=1 constant, GAP=4; start with tbm_hdr_data=16'hA53C, tbm_trl_data=16'h0081, nroc=0 → dout sequence 7,F,C,A,5,3,C,7,F,E,0,0,8,1,F,F,F,F; busy falls after the 4th F; in_ready never asserted.
- nroc=2, roc_stat=2'b10, upstream provides hit 24'h123456, eor, eor → after header: 7,F,A, 1,2,3,4,5,6, 7,F,A, then trailer; exactly 3 in_ready pulses.
- ena asserted every 5th clk80 cycle → dout changes only on ena edges; in_ready high exactly one cycle per handshake; stream identical to the previous case.
- in_valid held low for 3 ena edges at first ROC handshake → three 1111 nibbles inserted, underrun=1, frame completes normally; next accepted start clears underrun.
- start pulsed while busy (mid-PX and during GAP) → ignored, frame unchanged; start after busy=0 → new header at the next ena edge with frame_start pulse.
- reset_n asserted low mid-PX → dout=1111, busy=0, in_ready=0 immediately (asynchronous); after release the next start produces a clean frame.
